shader_result_wb: RTL and testbench

SHADER_RESULT_WB -- requirements
Module: shader_result_wb

---
 rtl/shader_result_wb.sv | 161 ++++++++++++++++
 tb/tb_shader_result_wb.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shader_result_wb.sv
`timescale 1ns/1ps
// shader_result_wb
// Queues shader results in a small FIFO. Each entry holds one scalar and
// LANES vector lanes. The entries are then written back one word at a time,
// so each result takes LANES+1 words: first the scalar (idx 0), then lanes
// 0..LANES-1 (idx 1..LANES).
//
// Ports:
//   clk, rst_n                 clock and asynchronous active-low reset
//   in_valid/in_ready          result input handshake
//   in_result_s, in_result_v   scalar result and packed vector result
//                              (lane i is bits [i*WIDTH +: WIDTH])
//   out_valid/out_ready        writeback word handshake
//   out_data, out_idx          writeback word and its index
//   out_last                   marks the final word of a result
//   fifo_count                 number of occupied FIFO entries
//   result_cnt                 number of results fully written back (wraps)
module shader_result_wb #(
    parameter int WIDTH = 32,
    parameter int LANES = 4,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_result_s,
    input  logic [WIDTH*LANES-1:0]       in_result_v,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(LANES+1)-1:0]   out_idx,
    output logic                         out_last,
    output logic [$clog2(DEPTH):0]       fifo_count,
    output logic [15:0]                  result_cnt
);
    localparam int IDX_W   = $clog2(LANES + 1);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = WIDTH * (LANES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    // Storage: scalar in the low word, lanes above it, so word k of an
    // entry (k = out_idx) sits at bits [k*WIDTH +: WIDTH].
    logic [ENTRY_W-1:0] mem [DEPTH];

    logic [0:0]       state_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [15:0]      result_cnt_reg;

    logic             push;
    logic             send_hs;
    logic             pop;
    logic [ENTRY_W-1:0] head_entry;
    logic [WIDTH-1:0] head_words [LANES+1];

    // Ready depends only on registered occupancy: a full FIFO refuses a
    // new result even in the cycle its head is being popped.
    assign in_ready   = (count_reg != FULL_CNT);
    assign push       = in_valid && in_ready;
    assign send_hs    = (state_reg == SEND) && out_ready;
    assign pop        = send_hs && (idx_reg == LAST_IDX);

    assign out_valid  = (state_reg == SEND);
    assign out_idx    = idx_reg;
    assign out_last   = (state_reg == SEND) && (idx_reg == LAST_IDX);
    assign fifo_count = count_reg;
    assign result_cnt = result_cnt_reg;

    // Data storage is not reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {in_result_v, in_result_s};
        end
    end

    assign head_entry = mem[rd_ptr_reg];

    generate
        for (genvar gi = 0; gi <= LANES; gi++) begin : g_words
            assign head_words[gi] = head_entry[gi*WIDTH +: WIDTH];
        end
    endgenerate

    always_comb begin
        out_data = '0;
        for (int k = 0; k <= LANES; k++) begin
            if (idx_reg == IDX_W'(k)) begin
                out_data = head_words[k];
            end
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Serializer FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            result_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    idx_reg <= '0;
                    if (count_reg != '0) begin
                        state_reg <= SEND;
                    end
                end
                SEND: begin
                    if (send_hs) begin
                        if (idx_reg == LAST_IDX) begin
                            idx_reg        <= '0;
                            result_cnt_reg <= result_cnt_reg + 16'd1;
                            // Another entry already queued behind the head:
                            // continue without a bubble.
                            if (count_reg > CNT_W'(1)) begin
                                state_reg <= SEND;
                            end else begin
                                state_reg <= IDLE;
                            end
                        end else begin
                            idx_reg <= idx_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    idx_reg   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_shader_result_wb.sv
`timescale 1ns/1ps
module tb_shader_result_wb;
    localparam int WIDTH = 32;
    localparam int LANES = 4;
    localparam int DEPTH = 4;
    localparam int IDX_W = $clog2(LANES + 1);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                   clk;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_result_s;
    logic [WIDTH*LANES-1:0] in_result_v;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       out_data;
    logic [IDX_W-1:0]       out_idx;
    logic                   out_last;
    logic [CNT_W-1:0]       fifo_count;
    logic [15:0]            result_cnt;

    shader_result_wb #(.WIDTH(WIDTH), .LANES(LANES), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result_s(in_result_s), .in_result_v(in_result_v),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
        .fifo_count(fifo_count), .result_cnt(result_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               idx;
        bit               last;
    } word_t;

    // Reference model: a queue of expected writeback words plus counts of
    // queued results and completed results.
    word_t exp_q[$];
    int    model_count   = 0;
    int    model_results = 0;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor / scoreboard: inputs change at posedge+1, so at negedge the
    // values that will be sampled at the next posedge are already stable.
    bit               prev_stall = 0;
    logic [WIDTH-1:0] prev_data;
    logic [IDX_W-1:0] prev_idx;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            model_count   = 0;
            model_results = 0;
            prev_stall    = 0;
        end else begin
            bit popped;
            word_t w;
            popped = 0;
            check("fifo_count", 64'(fifo_count), 64'(model_count));
            check("in_ready", 64'(in_ready), 64'(model_count != DEPTH));
            check("result_cnt", 64'(result_cnt), 64'(model_results % 65536));
            check("out_last_rule", 64'(out_last), 64'(out_valid && (out_idx == LANES)));
            if (prev_stall) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_data", 64'(out_data), 64'(prev_data));
                check("stall_idx", 64'(out_idx), 64'(prev_idx));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_word: got data 0x%0h idx %0d, expected none", out_data, out_idx);
                end else begin
                    w = exp_q.pop_front();
                    check("wb_data", 64'(out_data), 64'(w.data));
                    check("wb_idx", 64'(out_idx), 64'(w.idx));
                    check("wb_last", 64'(out_last), 64'(w.last));
                    popped = w.last;
                end
            end
            if (in_valid && in_ready) begin
                for (int k = 0; k <= LANES; k++) begin
                    w.data = (k == 0) ? in_result_s : in_result_v[(k-1)*WIDTH +: WIDTH];
                    w.idx  = k;
                    w.last = (k == LANES);
                    exp_q.push_back(w);
                end
                model_count++;
            end
            if (popped) begin
                model_count--;
                model_results++;
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_idx   = out_idx;
        end
    end

    function automatic logic [WIDTH*LANES-1:0] rand_vec();
        logic [WIDTH*LANES-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*WIDTH +: WIDTH] = $urandom;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_result(input logic [WIDTH-1:0] s, input logic [WIDTH*LANES-1:0] v);
        bit ok;
        ok = 0;
        in_result_s = s;
        in_result_v = v;
        in_valid    = 1'b1;
        for (int t = 0; t < 500 && !ok; t++) begin
            ok = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!ok) begin
            compared++;
            mismatched++;
            $display("FAIL push_timeout: in_ready never 1 within 500 cycles");
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int t = 0; t < 300 && (fifo_count != 0 || out_valid); t++) tick();
        check("drain_done", 64'(fifo_count != 0 || out_valid), 64'd0);
    endtask

    task automatic wait_idx(input int target);
        for (int t = 0; t < 100 && !(out_valid && out_idx == target); t++) tick();
        check("wait_idx", 64'(out_valid && out_idx == target), 64'd1);
    endtask

    bit run_bp;
    bit pat [10] = '{1, 0, 0, 1, 0, 1, 1, 0, 1, 1};

    initial begin
        logic [WIDTH*LANES-1:0] v;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        in_result_s = '0;
        in_result_v = '0;

        // Reset state
        tick();
        tick();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_idx", 64'(out_idx), 64'd0);
        check("rst_out_last", 64'(out_last), 64'd0);
        check("rst_fifo_count", 64'(fifo_count), 64'd0);
        check("rst_result_cnt", 64'(result_cnt), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;
        tick();

        // Single result, out_ready held high: latency and word sequence
        out_ready   = 1'b1;
        v           = {32'h13, 32'h12, 32'h11, 32'h10};
        in_result_s = 32'hA;
        in_result_v = v;
        in_valid    = 1'b1;
        tick();
        in_valid = 1'b0;
        check("latency_not_yet", 64'(out_valid), 64'd0);
        tick();
        for (int k = 0; k <= LANES; k++) begin
            check("seq_valid", 64'(out_valid), 64'd1);
            check("seq_idx", 64'(out_idx), 64'(k));
            check("seq_data", 64'(out_data), (k == 0) ? 64'hA : 64'(32'h10 + k - 1));
            check("seq_last", 64'(out_last), 64'(k == LANES));
            tick();
        end
        check("single_result_cnt", 64'(result_cnt), 64'd1);
        check("single_idle", 64'(out_valid), 64'd0);

        // Fill with out_ready low, refuse a fifth, then drain without bubble
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) push_result($urandom, rand_vec());
        check("full_count", 64'(fifo_count), 64'(DEPTH));
        check("full_in_ready", 64'(in_ready), 64'd0);
        in_result_s = $urandom;
        in_result_v = rand_vec();
        in_valid    = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        check("full_refused", 64'(fifo_count), 64'(DEPTH));
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH * (LANES + 1); i++) begin
            check("no_bubble", 64'(out_valid), 64'd1);
            tick();
        end
        check("fill_result_cnt", 64'(result_cnt), 64'(1 + DEPTH));
        check("fill_empty", 64'(fifo_count), 64'd0);

        // Directed backpressure pattern during one result
        out_ready = 1'b0;
        push_result($urandom, rand_vec());
        for (int i = 0; i < 10; i++) begin
            out_ready = pat[i];
            tick();
        end
        drain();

        // Simultaneous push and pop at fifo_count == 2
        out_ready = 1'b0;
        push_result($urandom, rand_vec());
        push_result($urandom, rand_vec());
        check("pp_count_before", 64'(fifo_count), 64'd2);
        out_ready = 1'b1;
        wait_idx(LANES);
        in_result_s = $urandom;
        in_result_v = rand_vec();
        in_valid    = 1'b1;
        tick();
        in_valid = 1'b0;
        check("pp_count_after", 64'(fifo_count), 64'd2);
        drain();

        // Randomized traffic with random backpressure
        run_bp = 1;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 3)) tick();
                    push_result($urandom, rand_vec());
                end
                run_bp = 0;
            end
            begin
                while (run_bp) begin
                    out_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        drain();

        // Reset in the middle of a result with entries queued behind it
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_result($urandom, rand_vec());
        out_ready = 1'b1;
        wait_idx(2);
        out_ready = 1'b0;
        check("pre_reset_cnt", 64'(result_cnt), 64'(model_results));
        check("pre_reset_count", 64'(fifo_count), 64'd3);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_idx", 64'(out_idx), 64'd0);
        check("mid_rst_out_last", 64'(out_last), 64'd0);
        check("mid_rst_fifo_count", 64'(fifo_count), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_result_cnt", 64'(result_cnt), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("post_rst_idle", 64'(out_valid), 64'd0);
            tick();
        end
        push_result($urandom, rand_vec());
        drain();
        check("post_rst_result_cnt", 64'(result_cnt), 64'd1);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
